// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: opcode encoding, FSM states and
// small opcode-classification helpers.
package mdu_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    function automatic logic is_arith_op(input md_op_t op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_mul_op(input md_op_t op);
        return (op == MULT) || (op == MULTU);
    endfunction

    function automatic logic is_signed_op(input md_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the pipeline (master) and the multiply/divide unit (slave).
interface mul_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    md_op_t           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_signfix.sv
// Combinational sign handling: operand magnitudes on issue, and sign correction
// of the unsigned 2*WIDTH result (product, or remainder:quotient pair).
module mdu_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic [WIDTH-1:0]   mag_a_o,
    output logic [WIDTH-1:0]   mag_b_o,
    output logic               neg_a_o,
    output logic               neg_b_o,
    input  logic [2*WIDTH-1:0] raw_i,
    input  logic               is_mul_i,
    input  logic               neg_a_i,
    input  logic               neg_b_i,
    output logic [2*WIDTH-1:0] res_o
);
    logic [WIDTH-1:0] raw_hi;
    logic [WIDTH-1:0] raw_lo;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    always_comb begin
        neg_a_o = signed_i & a_i[WIDTH-1];
        neg_b_o = signed_i & b_i[WIDTH-1];
        mag_a_o = neg_a_o ? -a_i : a_i;
        mag_b_o = neg_b_o ? -b_i : b_i;
    end

    // Divide: quotient takes the XOR of the signs, remainder follows the dividend.
    always_comb begin
        raw_hi = raw_i[2*WIDTH-1:WIDTH];
        raw_lo = raw_i[WIDTH-1:0];
        fix_hi = neg_a_i ? -raw_hi : raw_hi;
        fix_lo = (neg_a_i ^ neg_b_i) ? -raw_lo : raw_lo;
        if (is_mul_i) begin
            res_o = (neg_a_i ^ neg_b_i) ? -raw_i : raw_i;
        end else begin
            res_o = {fix_hi, fix_lo};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shift register and one WIDTH+1-bit adder/subtractor serve both algorithms.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic          clk,
    input logic          reset,
    mul_div_unit_if.slave bus
);
    mdu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               is_mul_q, is_mul_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg_a, neg_b;
    logic [2*WIDTH-1:0] fixed;

    logic [WIDTH:0]     add_x, add_y, add_s;
    logic [2*WIDTH-1:0] acc_step;

    mdu_signfix #(
        .WIDTH (WIDTH)
    ) u_signfix (
        .a_i      (bus.a),
        .b_i      (bus.b),
        .signed_i (is_signed_op(bus.op)),
        .mag_a_o  (mag_a),
        .mag_b_o  (mag_b),
        .neg_a_o  (neg_a),
        .neg_b_o  (neg_b),
        .raw_i    (acc_q),
        .is_mul_i (is_mul_q),
        .neg_a_i  (sign_a_q),
        .neg_b_i  (sign_b_q),
        .res_o    (fixed)
    );

    // Multiply adds m to the upper half; divide subtracts m from the upper half
    // shifted left by one (the restoring trial). Bit WIDTH is carry or borrow.
    always_comb begin
        add_x = is_mul_q ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} : acc_q[2*WIDTH-1:WIDTH-1];
        add_y = is_mul_q ? {1'b0, m_q} : ~{1'b0, m_q};
        add_s = add_x + add_y + (WIDTH+1)'(!is_mul_q);
    end

    always_comb begin
        if (is_mul_q) begin
            acc_step = acc_q[0] ? {add_s, acc_q[WIDTH-1:1]}
                                : {1'b0, acc_q[2*WIDTH-1:1]};
        end else begin
            acc_step = add_s[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        m_d      = m_q;
        is_mul_d = is_mul_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start && !bus.cancel) begin
                    if (is_arith_op(bus.op)) begin
                        state_d  = RUN;
                        cnt_d    = CNT_W'(WIDTH);
                        busy_d   = 1'b1;
                        is_mul_d = is_mul_op(bus.op);
                        sign_a_d = neg_a;
                        sign_b_d = neg_b;
                        if (is_mul_op(bus.op)) begin
                            acc_d = {{WIDTH{1'b0}}, mag_b};
                            m_d   = mag_a;
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, mag_a};
                            m_d   = mag_b;
                        end
                    end else if (bus.op == MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.op == MTLO) begin
                        lo_d = bus.a;
                    end
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                if (!bus.cancel) begin
                    // A zero divisor leaves the dividend in the remainder half already.
                    hi_d   = fixed[2*WIDTH-1:WIDTH];
                    lo_d   = (!is_mul_q && (m_q == '0)) ? '1 : fixed[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            is_mul_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            is_mul_q <= is_mul_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed WIDTH=32 cases plus randomised WIDTH=8 traffic,
// both compared every cycle against an arithmetic model of the unit.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst32 = 1'b1;
    logic rst8 = 1'b1;
    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) if32 ();
    mul_div_unit_if #(.WIDTH(8))  if8 ();

    mul_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst32), .bus(if32.slave));
    mul_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst8),  .bus(if8.slave));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic        pend;
        int          rem;
        logic [31:0] rhi;
        logic [31:0] rlo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        logic        done;
    } mst_t;

    mst_t m32, m8;

    // Architectural result of one op at width w, straight from signed/unsigned arithmetic.
    function automatic void ref_op(input int w, input md_op_t op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] ehi,
                                   output logic [31:0] elo);
        logic [31:0] mask;
        logic [63:0] ua, ub, up;
        longint sa, sb, q, r;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ua = {32'd0, a & mask};
        ub = {32'd0, b & mask};
        sa = longint'(ua);
        sb = longint'(ub);
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
        ehi = '0;
        elo = '0;
        case (op)
            MULT, MULTU: begin
                up  = (op == MULT) ? 64'(sa * sb) : ua * ub;
                ehi = 32'(up >> w) & mask;
                elo = 32'(up) & mask;
            end
            DIV, DIVU: begin
                if (ub == 64'd0) begin
                    ehi = a & mask;
                    elo = mask;
                end else begin
                    if (op == DIV) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'(ua / ub);
                        r = longint'(ua % ub);
                    end
                    ehi = 32'(r) & mask;
                    elo = 32'(q) & mask;
                end
            end
            default: ;
        endcase
    endfunction

    // Timing model: an op issued at an edge completes at the (w+1)-th edge after it.
    function automatic mst_t mstep(input mst_t s, input int w, input logic start,
                                   input md_op_t op, input logic [31:0] a,
                                   input logic [31:0] b, input logic cancel);
        mst_t n;
        logic [31:0] mask;
        logic [31:0] rh, rl;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        n = s;
        n.done = 1'b0;
        if (s.pend) begin
            if (cancel) begin
                n.pend = 1'b0;
                n.busy = 1'b0;
            end else begin
                n.rem = s.rem - 1;
                if (n.rem == 0) begin
                    n.hi   = s.rhi;
                    n.lo   = s.rlo;
                    n.done = 1'b1;
                    n.pend = 1'b0;
                    n.busy = 1'b0;
                end
            end
        end else if (start && !cancel) begin
            if (op == MTHI) begin
                n.hi = a & mask;
            end else if (op == MTLO) begin
                n.lo = a & mask;
            end else begin
                ref_op(w, op, a, b, rh, rl);
                n.pend = 1'b1;
                n.busy = 1'b1;
                n.rem  = w + 1;
                n.rhi  = rh;
                n.rlo  = rl;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst32) begin
        if (rst32) m32 <= '0;
        else m32 <= mstep(m32, 32, if32.start, if32.op, if32.a, if32.b, if32.cancel);
    end

    always @(posedge clk or posedge rst8) begin
        if (rst8) m8 <= '0;
        else m8 <= mstep(m8, 8, if8.start, if8.op, 32'(if8.a), 32'(if8.b), if8.cancel);
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one WIDTH=32 op and reports after which edge done was first seen.
    task automatic run32(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         output int done_edge);
        if32.start = 1'b1;
        if32.op    = op;
        if32.a     = a;
        if32.b     = b;
        tick();
        if32.start = 1'b0;
        done_edge  = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (if32.done && done_edge < 0) done_edge = k;
        end
    endtask

    function automatic logic [7:0] rnd8();
        logic [7:0] sp [5];
        sp[0] = 8'h00; sp[1] = 8'h80; sp[2] = 8'hFF; sp[3] = 8'h01; sp[4] = 8'h7F;
        return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : 8'($urandom);
    endfunction

    initial begin
        int de;
        int seen;
        logic [31:0] eh, el;

        if32.start = 1'b0; if32.op = MULT; if32.a = '0; if32.b = '0; if32.cancel = 1'b0;
        if8.start  = 1'b0; if8.op  = MULT; if8.a  = '0; if8.b  = '0; if8.cancel  = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    chk("cmp32", 80'({if32.busy, if32.done, if32.hi, if32.lo}),
                        80'({m32.busy, m32.done, m32.hi, m32.lo}));
                    chk("cmp8", 80'({if8.busy, if8.done, if8.hi, if8.lo}),
                        80'({m8.busy, m8.done, m8.hi[7:0], m8.lo[7:0]}));
                end
            end
        join_none

        // Model pins against hand-computed results
        ref_op(32, MULT, 32'hFFFF_FFFF, 32'h2, eh, el);
        chk("model_mult", 80'({eh, el}), 80'({32'hFFFF_FFFF, 32'hFFFF_FFFE}));
        ref_op(32, DIV, 32'hFFFF_FFF9, 32'h2, eh, el);
        chk("model_div", 80'({eh, el}), 80'({32'hFFFF_FFFF, 32'hFFFF_FFFD}));
        ref_op(8, DIV, 32'h80, 32'hFF, eh, el);
        chk("model_div8_ovf", 80'({eh, el}), 80'({32'h0, 32'h80}));

        repeat (3) tick();
        chk("reset32", 80'({if32.busy, if32.done, if32.hi, if32.lo}), 80'(0));
        chk("reset8", 80'({if8.busy, if8.done, if8.hi, if8.lo}), 80'(0));
        rst32 = 1'b0;
        rst8  = 1'b0;
        chk_en = 1'b1;

        run32(MULT, 32'hFFFF_FFFF, 32'h2, de);
        chk("mult_done_edge", 80'(de), 80'(33));
        chk("mult", 80'({if32.hi, if32.lo}), 80'({32'hFFFF_FFFF, 32'hFFFF_FFFE}));
        run32(MULTU, 32'hFFFF_FFFF, 32'h2, de);
        chk("multu", 80'({if32.hi, if32.lo}), 80'({32'h1, 32'hFFFF_FFFE}));
        run32(DIV, 32'hFFFF_FFF9, 32'h2, de);
        chk("div_neg", 80'({if32.hi, if32.lo}), 80'({32'hFFFF_FFFF, 32'hFFFF_FFFD}));
        run32(DIVU, 32'd100, 32'h0, de);
        chk("divu_by_zero", 80'({if32.hi, if32.lo}), 80'({32'd100, 32'hFFFF_FFFF}));
        run32(DIV, 32'h8000_0000, 32'hFFFF_FFFF, de);
        chk("div_ovf_done_edge", 80'(de), 80'(33));
        chk("div_ovf", 80'({if32.hi, if32.lo}), 80'({32'h0, 32'h8000_0000}));

        // MTLO: written at the issue edge, no busy
        if32.start = 1'b1; if32.op = MTLO; if32.a = 32'hCAFE_0001;
        tick();
        if32.start = 1'b0;
        chk("mtlo", 80'({if32.busy, if32.lo}), 80'({1'b0, 32'hCAFE_0001}));

        // cancel beats start in IDLE
        if32.start = 1'b1; if32.op = MTHI; if32.a = 32'h5555; if32.cancel = 1'b1;
        tick();
        if32.start = 1'b0; if32.cancel = 1'b0;
        chk("mthi_cancelled", 80'(if32.hi), 80'(0));

        // DIVU 100/7 cancelled mid-run; a start during busy is dropped
        if32.start = 1'b1; if32.op = DIVU; if32.a = 32'd100; if32.b = 32'd7;
        tick();
        if32.start = 1'b0;
        repeat (3) tick();
        if32.start = 1'b1; if32.op = MTHI; if32.a = 32'h1234;
        tick();
        if32.start = 1'b0;
        repeat (5) tick();
        if32.cancel = 1'b1;
        tick();
        if32.cancel = 1'b0;
        chk("cancel_busy", 80'(if32.busy), 80'(0));
        chk("cancel_keep", 80'({if32.hi, if32.lo}), 80'({32'h0, 32'hCAFE_0001}));
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (if32.done) seen++;
        end
        chk("cancel_no_done", 80'(seen), 80'(0));
        run32(DIVU, 32'd100, 32'd7, de);
        chk("divu", 80'({if32.hi, if32.lo}), 80'({32'd2, 32'd14}));

        // Randomised WIDTH=8 traffic including starts while busy and cancels
        for (int c = 0; c < 2500; c++) begin
            int r;
            r = $urandom_range(0, 9);
            if8.start  = ($urandom_range(0, 2) == 0);
            if8.op     = (r < 8) ? md_op_t'(3'(r % 4)) : md_op_t'(3'(4 + r % 2));
            if8.a      = rnd8();
            if8.b      = rnd8();
            if8.cancel = ($urandom_range(0, 23) == 0);
            tick();
        end
        if8.start = 1'b0; if8.cancel = 1'b0;
        for (int k = 0; k < 20 && if8.busy; k++) tick();
        chk("rand8_idle", 80'(if8.busy), 80'(0));

        // Reset in the middle of RUN
        if8.start = 1'b1; if8.op = MTHI; if8.a = 8'hA5;
        tick();
        if8.op = DIV; if8.a = 8'h9C; if8.b = 8'h07;
        tick();
        if8.start = 1'b0;
        repeat (3) tick();
        chk("pre_reset_busy", 80'(if8.busy), 80'(1));
        rst8 = 1'b1;
        #1;
        chk("midrun_reset", 80'({if8.busy, if8.done, if8.hi, if8.lo}), 80'(0));
        repeat (2) tick();
        rst8 = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (if8.done) seen++;
        end
        chk("reset_no_done", 80'(seen), 80'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving operand and HI/LO width (even, >= 8).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), giving the iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to issue op; only honoured when idle.
REQ-006 op  input  3  MULT, MULTU, DIV, DIVU, MTHI, MTLO (md_op_t).
REQ-007 a, b  input  WIDTH  rs/rt operands (a = dividend, b = divisor).
REQ-008 cancel  input  1  pipeline flush; aborts the operation in flight.
REQ-009 busy  output  1  op in flight; drives the hazard unit's stall.
REQ-010 done  output  1  one-cycle pulse when HI/LO take a new mult/div result.
REQ-011 hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-012 SHALL use FSM states IDLE, RUN and FIX.
REQ-013 In IDLE with start=1 and cancel=0, MULT/MULTU/DIV/DIVU SHALL latch magnitudes and signs, load counter=WIDTH and go to RUN.
REQ-014 RUN SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide), decrementing counter, and enter FIX after WIDTH steps.
REQ-015 FIX SHALL apply sign correction, write HI/LO at its closing edge, and return to IDLE.
REQ-016 Latency: start sampled at edge 0 SHALL write HI/LO at edge WIDTH+1 and assert done for the following cycle only.
REQ-017 busy SHALL be high exactly in RUN and FIX, i.e. the cycles after edges 0..WIDTH.
REQ-018 MTHI/MTLO with start in IDLE SHALL write a into hi/lo at that edge, without busy or done.
REQ-019 start while busy SHALL be ignored; the op is not queued.
REQ-020 Multiply SHALL set {hi,lo} to the full 2*WIDTH-bit product, signed for MULT and unsigned for MULTU.
REQ-021 Divide SHALL set lo=quotient truncated toward zero and hi=remainder carrying the dividend's sign.
REQ-022 Divide by zero (b=0) SHALL give lo=all ones and hi=a, for both DIV and DIVU.
REQ-023 DIV of most-negative by -1 SHALL give lo=most-negative and hi=0 (wrap, no trap).
REQ-024 cancel=1 in RUN or FIX SHALL return to IDLE at the next edge, leave hi/lo unchanged, and suppress done.
REQ-025 cancel and start in the same IDLE cycle: cancel SHALL win and the op is dropped (MTHI/MTLO included).
REQ-026 FSM states outside the defined set SHALL recover to IDLE.

Reset
REQ-027 reset SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0.
REQ-028 reset mid-operation SHALL discard the operation, with no done at or after release.

Structure
REQ-029 Package mdu_pkg SHALL hold md_op_t (3-bit encoding) and mdu_state_t.
REQ-030 Sub-module mdu_signfix SHALL be the only sub-module: combinational abs/negate and 2*WIDTH result sign correction, parametrised by WIDTH.
REQ-031 Both algorithms SHALL share one 2*WIDTH shift register and one WIDTH+1-bit adder/subtractor.

Verification (WIDTH=32 unless stated)
REQ-032 MULT a=0xFFFFFFFF b=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; done exactly at cycle 34 after the start edge.
REQ-033 MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU 100/7 with cancel at cycle 10 -> no done, hi/lo keep prior values, busy low at cycle 11; a start during busy is ignored.
REQ-037 WIDTH=8 randomised signed/unsigned mul/div against a reference model, with reset asserted mid-RUN -> all outputs 0 and no done pulse.
